// File: rtl/addr_gen.sv
// Address generator: builds the 16-bit address bus from an 8-bit low-byte
// adder and a high-byte base/offset stage, and maintains the program counter.
// Optional stall support is enabled by defining ADDR_GEN_RDY_EN, which adds
// the rdy input; without it every clock advances.
module addr_gen (
   input  logic        clk,
   input  logic        reset,
`ifdef ADDR_GEN_RDY_EN
   input  logic        rdy,
`endif
   input  logic [11:0] ab_op,
   input  logic [7:0]  DB,
   input  logic [7:0]  REG,
   output logic [15:0] AB,
   output logic [15:0] PC,
   output logic        page_cross
);

   logic [15:0] ab_q, ab_d;
   logic [15:0] pc_q, pc_d;
   logic        pc_cross_q, pc_cross_d;
   logic        advance;

   logic [2:0]  pc_op;
   logic [1:0]  abh_sel;
   logic [1:0]  abh_add;
   logic [1:0]  abl_sel;
   logic [1:0]  abl_op;
   logic        abl_ci;

   logic [7:0]  abl_opa;
   logic [7:0]  abl_opb;
   logic [8:0]  abl_sum;
   logic        co;
   logic [7:0]  abh_base;
   logic [7:0]  abh_off;
   logic [7:0]  abh_next;
   logic [15:0] ab_next;

   assign pc_op   = ab_op[11:9];
   assign abh_sel = ab_op[8:7];
   assign abh_add = ab_op[6:5];
   assign abl_sel = ab_op[4:3];
   assign abl_op  = ab_op[2:1];
   assign abl_ci  = ab_op[0];

`ifdef ADDR_GEN_RDY_EN
   assign advance = rdy;
`else
   assign advance = 1'b1;
`endif

   // Low-byte adder: operand A, operand B and carry-in; bit 8 is the page carry.
   always_comb begin
      abl_opa = 8'h00;
      abl_opb = 8'h00;
      unique case (abl_op)
         2'b00:   abl_opa = REG;
         2'b01:   abl_opa = DB;
         2'b10:   abl_opa = pc_q[7:0];
         default: abl_opa = ab_q[7:0];
      endcase
      unique case (abl_sel)
         2'b01:   abl_opb = REG;
         2'b10:   abl_opb = DB;
         default: abl_opb = 8'h00;
      endcase
      abl_sum = {1'b0, abl_opa} + {1'b0, abl_opb} + {8'h00, abl_ci};
      co      = abl_sum[8];
   end

   // High byte: base plus small offset; 11 gives -1+co so a borrow-free
   // negative branch stays on the page while a carry cancels the decrement.
   always_comb begin
      abh_base = 8'h00;
      abh_off  = 8'h00;
      unique case (abh_sel)
         2'b00:   abh_base = 8'h00;
         2'b01:   abh_base = ab_q[15:8];
         2'b10:   abh_base = pc_q[15:8];
         default: abh_base = DB;
      endcase
      unique case (abh_add)
         2'b00:   abh_off = 8'h00;
         2'b01:   abh_off = 8'h01;
         2'b10:   abh_off = {7'h00, co};
         default: abh_off = co ? 8'h00 : 8'hFF;
      endcase
      abh_next = abh_base + abh_off;
      ab_next  = {abh_next, abl_sum[7:0]};
   end

   // Next-state for address, program counter and page-cross flag.
   always_comb begin
      ab_d       = ab_next;
      pc_d       = pc_q;
      pc_cross_d = co;
      unique case (pc_op)
         3'b001:  pc_d = ab_next;
         3'b010:  pc_d = pc_q + 16'h0001;
         3'b011:  pc_d = ab_next + 16'h0001;
         3'b100:  pc_d = ab_q;
         default: pc_d = pc_q;
      endcase
   end

   // State registers; reset wins over stall and any pending update.
   always_ff @(posedge clk) begin
      if (reset) begin
         ab_q       <= 16'hFFFC;
         pc_q       <= 16'h0000;
         pc_cross_q <= 1'b0;
      end else if (advance) begin
         ab_q       <= ab_d;
         pc_q       <= pc_d;
         pc_cross_q <= pc_cross_d;
      end
   end

   assign AB         = ab_q;
   assign PC         = pc_q;
   assign page_cross = pc_cross_q;

endmodule
